// File: rtl/axil_single_req_client_pkg.sv
// rtl/axil_single_req_client_pkg.sv - shared types and constants for the AXI-Lite single-request client
package axil_single_req_client_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 32;
  localparam int unsigned StrbW = DataW / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // One queued downstream request; reads carry wdata=0 and be=all ones.
  typedef struct packed {
    logic             we;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
    logic [StrbW-1:0] be;
  } req_entry_t;

endpackage

// File: rtl/axil_single_req_client_if.sv
// rtl/axil_single_req_client_if.sv - AXI4-Lite port bundle with host (master) and device (slave) views
interface axil_single_req_client_if
  import axil_single_req_client_pkg::*;
#(
  parameter int unsigned data_width_p = DataW,
  parameter int unsigned addr_width_p = AddrW
);

  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;

  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;

  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;

  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_single_req_client_resp_buf.sv
// rtl/axil_single_req_client_resp_buf.sv - one-entry valid/data response buffer with yumi pop
module single_resp_buf #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               full_q, full_d;
  logic [width_p-1:0] data_q, data_d;

  // Capture only into an empty slot; a strobe arriving while full is dropped.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (v_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (yumi_i) begin
      full_d = 1'b0;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign v_o    = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/axil_single_req_client.sv
// rtl/axil_single_req_client.sv - AXI4-Lite slave to single-outstanding req/gnt + valid response bridge
module axil_single_req_client
  import axil_single_req_client_pkg::*;
#(
  parameter int unsigned data_width_p = DataW,
  parameter int unsigned addr_width_p = AddrW,
  parameter int unsigned fifo_els_p   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  axil_single_req_client_if.slave   s_axil,
  output logic                      req_o,
  input  logic                      gnt_i,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      we_o,
  output logic [data_width_p-1:0]   wdata_o,
  output logic [data_width_p/8-1:0] be_o,
  input  logic                      valid_i,
  input  logic [data_width_p-1:0]   rdata_i
);

  localparam int unsigned ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int unsigned cnt_w = $clog2(fifo_els_p + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(fifo_els_p - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(fifo_els_p);

  req_entry_t       mem_q [fifo_els_p];
  req_entry_t       enq_entry;
  req_entry_t       head;
  logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty;
  logic             wr_enq, rd_enq, enq, accept;

  logic             inflight_q, inflight_d;
  logic             type_q, type_d;
  logic             rsp_v;
  logic [data_width_p-1:0] rsp_data;
  logic             rsp_hs;
  logic             unused_prot;

  // prot carries no meaning for this peripheral.
  assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

  assign fifo_full  = (cnt_q == full_cnt);
  assign fifo_empty = (cnt_q == '0);

  // Write needs both AW and W together; a read only goes in when no write does.
  assign wr_enq = s_axil.awvalid & s_axil.wvalid & ~fifo_full;
  assign rd_enq = s_axil.arvalid & ~fifo_full & ~(s_axil.awvalid & s_axil.wvalid);
  assign enq    = wr_enq | rd_enq;

  assign s_axil.awready = wr_enq;
  assign s_axil.wready  = wr_enq;
  assign s_axil.arready = ~fifo_full & ~(s_axil.awvalid & s_axil.wvalid);

  // Build the entry to enqueue from whichever channel wins this cycle.
  always_comb begin
    enq_entry = '0;
    if (wr_enq) begin
      enq_entry.we    = 1'b1;
      enq_entry.addr  = s_axil.awaddr;
      enq_entry.wdata = s_axil.wdata;
      enq_entry.be    = s_axil.wstrb;
    end else begin
      enq_entry.addr  = s_axil.araddr;
      enq_entry.be    = '1;
    end
  end

  assign head    = mem_q[rptr_q];
  assign req_o   = ~fifo_empty & ~inflight_q;
  assign accept  = req_o & gnt_i;
  assign addr_o  = head.addr;
  assign we_o    = head.we;
  assign wdata_o = head.wdata;
  assign be_o    = head.be;

  // FIFO pointer and occupancy next-state; enqueue and pop may coincide.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (enq) begin
      wptr_d = (wptr_q == last_ptr) ? '0 : wptr_q + 1'b1;
    end
    if (accept) begin
      rptr_d = (rptr_q == last_ptr) ? '0 : rptr_q + 1'b1;
    end
    case ({enq, accept})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(fifo_els_p); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (enq) begin
        mem_q[wptr_q] <= enq_entry;
      end
    end
  end

  assign rsp_hs = (s_axil.bvalid & s_axil.bready) | (s_axil.rvalid & s_axil.rready);

  // Outstanding flag and request type; a new accept wins over a completing handshake.
  always_comb begin
    inflight_d = inflight_q;
    type_d     = type_q;
    if (accept) begin
      inflight_d = 1'b1;
      type_d     = head.we;
    end else if (rsp_hs) begin
      inflight_d = 1'b0;
    end
  end

  // Outstanding flag and request type registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      type_q     <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      type_q     <= type_d;
    end
  end

  // Responses with nothing outstanding are stray and never reach the buffer.
  single_resp_buf #(
    .width_p (data_width_p)
  ) u_resp_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .v_i    (valid_i & inflight_q),
    .data_i (rdata_i),
    .v_o    (rsp_v),
    .data_o (rsp_data),
    .yumi_i (rsp_hs)
  );

  assign s_axil.bvalid = rsp_v & type_q;
  assign s_axil.bresp  = RESP_OKAY;
  assign s_axil.rvalid = rsp_v & ~type_q;
  assign s_axil.rdata  = type_q ? '0 : rsp_data;
  assign s_axil.rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axil_single_req_client.sv
// tb/tb_axil_single_req_client.sv - directed self-checking bench for axil_single_req_client
module tb_axil_single_req_client;

  logic        clk;
  logic        rst_ni;
  logic        req_o;
  logic        gnt_i;
  logic [31:0] addr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        valid_i;
  logic [31:0] rdata_i;

  int checks;
  int errors;

  axil_single_req_client_if #(.data_width_p(32), .addr_width_p(32)) axil ();

  axil_single_req_client #(
    .data_width_p (32),
    .addr_width_p (32),
    .fifo_els_p   (2)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .s_axil  (axil),
    .req_o   (req_o),
    .gnt_i   (gnt_i),
    .addr_o  (addr_o),
    .we_o    (we_o),
    .wdata_o (wdata_o),
    .be_o    (be_o),
    .valid_i (valid_i),
    .rdata_i (rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] ret;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    axil.awaddr  = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata   = '0; axil.wstrb  = '0; axil.wvalid  = 1'b0;
    axil.bready  = 1'b0;
    axil.araddr  = '0; axil.arprot = '0; axil.arvalid = 1'b0;
    axil.rready  = 1'b0;
    gnt_i = 1'b0; valid_i = 1'b0; rdata_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    idle();

    vecs[0] = '{we: 1'b1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, strb: 4'hF, ret: 32'h0,
                exp_wdata: 32'hDEAD_BEEF, exp_be: 4'hF};
    vecs[1] = '{we: 1'b0, addr: 32'h0000_0204, wdata: 32'h0, strb: 4'h0, ret: 32'h5A5A_0001,
                exp_wdata: 32'h0, exp_be: 4'hF};
    vecs[2] = '{we: 1'b1, addr: 32'h0000_03FC, wdata: 32'h1234_5678, strb: 4'h5, ret: 32'hFFFF_FFFF,
                exp_wdata: 32'h1234_5678, exp_be: 4'h5};
    vecs[3] = '{we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0, strb: 4'h0, ret: 32'hFFFF_FFFF,
                exp_wdata: 32'h0, exp_be: 4'hF};

    // Reset state
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_bvalid", axil.bvalid, 0);
    chk("rst_rvalid", axil.rvalid, 0);
    chk("rst_bresp", axil.bresp, 0);
    chk("rst_rresp", axil.rresp, 0);
    chk("rst_rdata", axil.rdata, 0);
    chk("rst_arready", axil.arready, 1);
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    #1;
    chk("rst_awready", axil.awready, 1);
    chk("rst_wready", axil.wready, 1);
    idle();
    @(posedge clk);
    #2 rst_ni = 1'b1;
    cyc();

    // Single transactions from the table, granted immediately, response 2 cycles later
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      if (v.we) begin
        axil.awaddr = v.addr; axil.wdata = v.wdata; axil.wstrb = v.strb;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      end else begin
        axil.araddr = v.addr; axil.arvalid = 1'b1;
      end
      #1;
      chk($sformatf("v%0d_ready", i), v.we ? axil.awready : axil.arready, 1);
      chk($sformatf("v%0d_req_pre", i), req_o, 0);
      cyc();
      axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
      #1;
      chk($sformatf("v%0d_req", i), req_o, 1);
      chk($sformatf("v%0d_addr", i), addr_o, v.addr);
      chk($sformatf("v%0d_we", i), we_o, v.we);
      chk($sformatf("v%0d_wdata", i), wdata_o, v.exp_wdata);
      chk($sformatf("v%0d_be", i), be_o, v.exp_be);
      gnt_i = 1'b1;
      cyc();
      gnt_i = 1'b0;
      #1;
      chk($sformatf("v%0d_req_inflight", i), req_o, 0);
      cyc();
      valid_i = 1'b1; rdata_i = v.ret;
      #1;
      chk($sformatf("v%0d_bvalid_early", i), axil.bvalid, 0);
      chk($sformatf("v%0d_rvalid_early", i), axil.rvalid, 0);
      cyc();
      valid_i = 1'b0; rdata_i = 32'h1357_9BDF;
      #1;
      chk($sformatf("v%0d_bvalid", i), axil.bvalid, v.we);
      chk($sformatf("v%0d_rvalid", i), axil.rvalid, !v.we);
      chk($sformatf("v%0d_resp", i), v.we ? axil.bresp : axil.rresp, 0);
      if (!v.we) chk($sformatf("v%0d_rdata", i), axil.rdata, v.ret);
      axil.bready = 1'b1; axil.rready = 1'b1;
      cyc();
      axil.bready = 1'b0; axil.rready = 1'b0;
      #1;
      chk($sformatf("v%0d_done_b", i), axil.bvalid, 0);
      chk($sformatf("v%0d_done_r", i), axil.rvalid, 0);
      chk($sformatf("v%0d_done_req", i), req_o, 0);
    end

    // Back-to-back: two writes then a read, grant tied high, FIFO fills
    gnt_i = 1'b1;
    axil.awaddr = 32'h10; axil.wdata = 32'hA; axil.wstrb = 4'hF;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    #1 chk("b2b_awready_a", axil.awready, 1);
    cyc();
    axil.awaddr = 32'h14; axil.wdata = 32'hB;
    #1;
    chk("b2b_req_a", req_o, 1);
    chk("b2b_addr_a", addr_o, 32'h10);
    chk("b2b_awready_b", axil.awready, 1);
    cyc();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    axil.araddr = 32'h18; axil.arvalid = 1'b1;
    #1;
    chk("b2b_arready_r", axil.arready, 1);
    chk("b2b_req_held", req_o, 0);
    cyc();
    axil.arvalid = 1'b0;
    axil.awaddr = 32'h1C; axil.wdata = 32'hD; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    valid_i = 1'b1;
    #1;
    chk("b2b_full_awready", axil.awready, 0);
    chk("b2b_full_wready", axil.wready, 0);
    chk("b2b_req_wait", req_o, 0);
    cyc();
    valid_i = 1'b0;
    #1;
    chk("b2b_bvalid_a", axil.bvalid, 1);
    chk("b2b_full_awready2", axil.awready, 0);
    chk("b2b_req_before_b", req_o, 0);
    axil.bready = 1'b1;
    cyc();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    #1;
    chk("b2b_bvalid_gone", axil.bvalid, 0);
    chk("b2b_req_b", req_o, 1);
    chk("b2b_addr_b", addr_o, 32'h14);
    chk("b2b_we_b", we_o, 1);
    cyc();
    #1;
    chk("b2b_req_b_inflight", req_o, 0);
    chk("b2b_awready_free", axil.arready, 1);
    valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    #1 chk("b2b_bvalid_b", axil.bvalid, 1);
    cyc();
    #1;
    chk("b2b_req_r", req_o, 1);
    chk("b2b_we_r", we_o, 0);
    chk("b2b_addr_r", addr_o, 32'h18);
    cyc();
    valid_i = 1'b1; rdata_i = 32'h0BAD_CAFE;
    cyc();
    valid_i = 1'b0;
    #1;
    chk("b2b_rvalid", axil.rvalid, 1);
    chk("b2b_rdata", axil.rdata, 32'h0BAD_CAFE);
    axil.rready = 1'b1;
    cyc();
    idle();
    #1;
    chk("b2b_rvalid_gone", axil.rvalid, 0);
    chk("b2b_idle_req", req_o, 0);

    // Simultaneous AW/W and AR: write first, read next cycle
    axil.awaddr = 32'h500; axil.wdata = 32'h55; axil.wstrb = 4'h3;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    axil.araddr = 32'h600; axil.arvalid = 1'b1;
    #1;
    chk("sim_awready", axil.awready, 1);
    chk("sim_arready_blocked", axil.arready, 0);
    cyc();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    #1;
    chk("sim_arready_next", axil.arready, 1);
    chk("sim_first_we", we_o, 1);
    chk("sim_first_addr", addr_o, 32'h500);
    cyc();
    axil.arvalid = 1'b0; gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    #1;
    chk("sim_bvalid", axil.bvalid, 1);
    chk("sim_rvalid_not", axil.rvalid, 0);
    axil.bready = 1'b1;
    cyc();
    axil.bready = 1'b0;
    #1;
    chk("sim_second_req", req_o, 1);
    chk("sim_second_we", we_o, 0);
    chk("sim_second_addr", addr_o, 32'h600);
    gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0; valid_i = 1'b1; rdata_i = 32'h66;
    cyc();
    valid_i = 1'b0;
    #1 chk("sim_rdata", axil.rdata, 32'h66);
    axil.rready = 1'b1;
    cyc();
    idle();

    // Backpressure: rready low 5 cycles, spurious valid_i dropped, queued read waits
    axil.araddr = 32'h40; axil.arvalid = 1'b1;
    cyc();
    axil.araddr = 32'h44; gnt_i = 1'b1;
    cyc();
    axil.arvalid = 1'b0; gnt_i = 1'b0;
    #1 chk("bp_req_inflight", req_o, 0);
    valid_i = 1'b1; rdata_i = 32'hCAFE_F00D;
    cyc();
    valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_rvalid_%0d", k), axil.rvalid, 1);
      chk($sformatf("bp_rdata_%0d", k), axil.rdata, 32'hCAFE_F00D);
      chk($sformatf("bp_req_%0d", k), req_o, 0);
      valid_i = (k == 1); rdata_i = 32'h1111_1111;
      cyc();
    end
    valid_i = 1'b0;
    #1 chk("bp_rdata_after_spurious", axil.rdata, 32'hCAFE_F00D);
    axil.rready = 1'b1;
    cyc();
    axil.rready = 1'b0;
    #1;
    chk("bp_rvalid_gone", axil.rvalid, 0);
    chk("bp_next_req", req_o, 1);
    chk("bp_next_addr", addr_o, 32'h44);
    gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0; valid_i = 1'b1; rdata_i = 32'h4444_4444;
    cyc();
    valid_i = 1'b0;
    #1 chk("bp_next_rdata", axil.rdata, 32'h4444_4444);
    axil.rready = 1'b1;
    cyc();
    idle();

    // Reset mid-flight: pending response and queued request are lost
    axil.araddr = 32'h700; axil.arvalid = 1'b1;
    cyc();
    axil.arvalid = 1'b0; gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0; axil.araddr = 32'h704; axil.arvalid = 1'b1;
    cyc();
    axil.arvalid = 1'b0; valid_i = 1'b1; rdata_i = 32'h77;
    cyc();
    valid_i = 1'b0;
    #1 chk("rm_rvalid_pre", axil.rvalid, 1);
    rst_ni = 1'b0;
    #1;
    chk("rm_rvalid_async", axil.rvalid, 0);
    chk("rm_rdata_async", axil.rdata, 0);
    chk("rm_req_async", req_o, 0);
    chk("rm_arready_async", axil.arready, 1);
    cyc();
    cyc();
    rst_ni = 1'b1;
    #1 chk("rm_fifo_empty", req_o, 0);
    valid_i = 1'b1; rdata_i = 32'h99;
    cyc();
    valid_i = 1'b0;
    #1 chk("rm_stray_ignored", axil.rvalid, 0);
    axil.araddr = 32'h708; axil.arvalid = 1'b1;
    cyc();
    axil.arvalid = 1'b0;
    #1;
    chk("rm_fresh_req", req_o, 1);
    chk("rm_fresh_addr", addr_o, 32'h708);
    gnt_i = 1'b1;
    cyc();
    gnt_i = 1'b0; valid_i = 1'b1; rdata_i = 32'h0001_2345;
    cyc();
    valid_i = 1'b0;
    #1;
    chk("rm_fresh_rvalid", axil.rvalid, 1);
    chk("rm_fresh_rdata", axil.rdata, 32'h0001_2345);
    axil.rready = 1'b1;
    cyc();
    axil.rready = 1'b0;
    #1 chk("rm_fresh_done", axil.rvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
